// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_ctrl_pkg
// Description : Shared opcodes, FSM state encoding and control-field
//               encodings for the RV32IF multi-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  // Major opcodes decoded by the controller
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_FSW = 7'b0100111;
  localparam logic [6:0] OP_FP  = 7'b1010011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_FPU_EXEC = 4'd11,
    S_FPU_WB   = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // ALU A operand select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result multiplexer select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU decoder request
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Trap cause
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_FPU_TO  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_fp_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : multicycle_fp_controller_if
// Description : Control bundle between the multi-cycle controller and the
//               RV32IF datapath.
//               Datapath -> controller : op, zero, mem_ready, fpu_done,
//                                        fpu_int_dest
//               Controller -> datapath : mux selects, write enables, FPU
//                                        launch, trap status
//               master = controller side, slave = datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_fp_controller_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       fpu_done;
  logic       fpu_int_dest;

  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       float_RegWrite;
  logic       float_store;
  logic       ResultSrc_float;
  logic       fpu_start;
  logic       illegal_op;
  logic [1:0] trap_cause;

  modport master (
    input  op, zero, mem_ready, fpu_done, fpu_int_dest,
    output PCWrite, AdrSrc, IRWrite, MemWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, float_RegWrite, float_store,
           ResultSrc_float, fpu_start, illegal_op, trap_cause
  );

  modport slave (
    output op, zero, mem_ready, fpu_done, fpu_int_dest,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, float_RegWrite, float_store,
           ResultSrc_float, fpu_start, illegal_op, trap_cause
  );
endinterface
`default_nettype wire

// File: rtl/imm_src_decoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_src_decoder
// Description : Combinational opcode -> immediate-format decoder.
//   i_op       in  7  opcode from the instruction register
//   o_imm_src  out 2  00 = I, 01 = S, 10 = B, 11 = J
// Revision    : 1.0 - initial release
// ============================================================================
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  wire logic [6:0] i_op,
  output logic      [1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_SW, OP_FSW: o_imm_src = IMM_S;
      OP_BEQ:        o_imm_src = IMM_B;
      OP_JAL:        o_imm_src = IMM_J;
      default:       o_imm_src = IMM_I;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_fp_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_fp_controller
// Description : Moore FSM sequencing fetch/decode/execute/memory/writeback
//               for the RV32IF multi-cycle datapath, with memory stall,
//               variable-latency FPU wait and sticky trap handling.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  master modport of multicycle_fp_controller_if (datapath controls)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_fp_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int FPU_TIMEOUT = 64,
  parameter bit ENABLE_F    = 1'b1
) (
  input wire logic                  clk,
  input wire logic                  rst,
  multicycle_fp_controller_if.master bus
);

  localparam int CNT_W = (FPU_TIMEOUT > 2) ? $clog2(FPU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FPU_TIMEOUT > 0) ? FPU_TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_int_dest;
  logic [1:0]       r_cause;
  logic             w_trap_set;
  logic [1:0]       w_trap_cause;
  logic [1:0]       w_imm_src;

  logic       w_pc_write, w_adr_src, w_ir_write, w_mem_write;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;
  logic       w_reg_write, w_freg_write, w_float_store, w_result_src_float;
  logic       w_fpu_start;

  imm_src_decoder u_imm_src_decoder (
    .i_op      (bus.op),
    .o_imm_src (w_imm_src)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_cnt      <= '0;
      r_int_dest <= 1'b0;
      r_cause    <= TRAP_NONE;
    end else begin
      r_state <= w_next;
      // Counter is held at zero outside FPU_EXEC, so it is zero on entry;
      // it saturates so that a disabled timeout never wraps back to zero.
      if (r_state != S_FPU_EXEC) begin
        r_cnt <= '0;
      end else if (!bus.fpu_done && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_FPU_EXEC) && bus.fpu_done) begin
        r_int_dest <= bus.fpu_int_dest;
      end
      if (w_trap_set) begin
        r_cause <= w_trap_cause;
      end
    end
  end

  always_comb begin
    w_next             = r_state;
    w_trap_set         = 1'b0;
    w_trap_cause       = TRAP_NONE;
    w_pc_write         = 1'b0;
    w_adr_src          = 1'b0;
    w_ir_write         = 1'b0;
    w_mem_write        = 1'b0;
    w_result_src       = RES_ALUOUT;
    w_alu_src_a        = SRCA_PC;
    w_alu_src_b        = SRCB_RS2;
    w_alu_op           = ALUOP_ADD;
    w_reg_write        = 1'b0;
    w_freg_write       = 1'b0;
    w_float_store      = 1'b0;
    w_result_src_float = 1'b0;
    w_fpu_start        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_FLW, OP_FSW: w_next = ENABLE_F ? S_MEMADR : S_TRAP;
          OP_R:           w_next = S_EXECUTER;
          OP_I:           w_next = S_EXECUTEI;
          OP_BEQ:         w_next = S_BEQ;
          OP_JAL:         w_next = S_JAL;
          OP_FP:          w_next = ENABLE_F ? S_FPU_EXEC : S_TRAP;
          default:        w_next = S_TRAP;
        endcase
        if (w_next == S_TRAP) begin
          w_trap_set   = 1'b1;
          w_trap_cause = TRAP_ILLEGAL;
        end
      end
      S_MEMADR: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
        w_next = ((bus.op == OP_LW) || (bus.op == OP_FLW)) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_READDATA;
        if (bus.op == OP_FLW) begin
          w_freg_write       = 1'b1;
          w_result_src_float = 1'b1;
        end else begin
          w_reg_write = 1'b1;
        end
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src     = 1'b1;
        w_mem_write   = 1'b1;
        w_float_store = (bus.op == OP_FSW);
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_op    = ALUOP_SUB;
        w_pc_write  = bus.zero;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_FOUR;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_FPU_EXEC: begin
        // Counter is zero only on the entry cycle, giving a one-cycle launch
        w_fpu_start = (r_cnt == '0);
        if (bus.fpu_done) begin
          w_next = S_FPU_WB;
        end else if ((FPU_TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_next       = S_TRAP;
          w_trap_set   = 1'b1;
          w_trap_cause = TRAP_FPU_TO;
        end
      end
      S_FPU_WB: begin
        w_reg_write  = r_int_dest;
        w_freg_write = !r_int_dest;
        w_next       = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Write strobes are suppressed combinationally while reset is asserted
  assign bus.PCWrite         = w_pc_write & ~rst;
  assign bus.IRWrite         = w_ir_write & ~rst;
  assign bus.MemWrite        = w_mem_write & ~rst;
  assign bus.RegWrite        = w_reg_write & ~rst;
  assign bus.float_RegWrite  = w_freg_write & ~rst;
  assign bus.fpu_start       = w_fpu_start & ~rst;
  assign bus.AdrSrc          = w_adr_src;
  assign bus.ResultSrc       = w_result_src;
  assign bus.ALUSrcA         = w_alu_src_a;
  assign bus.ALUSrcB         = w_alu_src_b;
  assign bus.ALUOp           = w_alu_op;
  assign bus.ImmSrc          = w_imm_src;
  assign bus.float_store     = w_float_store;
  assign bus.ResultSrc_float = w_result_src_float;
  assign bus.illegal_op      = (r_state == S_TRAP);
  assign bus.trap_cause      = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_fp_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_fp_controller
// Description : Self-checking bench for multicycle_fp_controller. Random
//               instruction streams with random memory/FPU stalls are
//               compared against per-instruction effect masks derived from
//               the instruction timing rules; directed cases cover traps,
//               timeout and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_fp_controller;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  multicycle_fp_controller_if bus ();
  multicycle_fp_controller_if bus2 ();

  multicycle_fp_controller #(.FPU_TIMEOUT(8), .ENABLE_F(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  multicycle_fp_controller #(.FPU_TIMEOUT(64), .ENABLE_F(1'b0)) dut_nf (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  wire [5:0] w_en  = {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                      bus.float_RegWrite, bus.fpu_start};
  wire [5:0] w_en2 = {bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite,
                      bus2.float_RegWrite, bus2.fpu_start};

  // Per-cycle stimulus for the instruction under test
  logic rdy  [32];
  logic dn   [32];
  logic zr   [32];
  logic idst [32];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_rdy(input int from);
    int t = from;
    while (t < 31 && !rdy[t]) t++;
    return t;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] opc);
    if (opc == OP_SW || opc == OP_FSW) return 2'b01;
    if (opc == OP_BEQ) return 2'b10;
    if (opc == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_R;
      3: return OP_I;
      4: return OP_BEQ;
      5: return OP_JAL;
      6: return OP_FLW;
      7: return OP_FSW;
      default: return OP_FP;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.op = OP_JAL; bus.mem_ready = 1'b1; bus.zero = 1'b1;
    bus.fpu_done = 1'b1; bus.fpu_int_dest = 1'b1;
    bus2.op = OP_JAL; bus2.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_enables", 32'(w_en), 32'd0);
    check_val("rst_enables_nf", 32'(w_en2), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0; bus.fpu_done = 1'b0;
    bus2.mem_ready = 1'b0;
    @(negedge clk);
    check_val("post_rst_state", 32'({bus.illegal_op, bus.trap_cause, w_en}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // One instruction starting in FETCH; expected behaviour is expressed as
  // bit masks over the instruction's cycles (bit t = asserted in cycle t).
  task automatic run_instr(input logic [6:0] opc);
    logic [31:0] x_ir, x_pc, x_rw, x_frw, x_mw, x_fs, x_st, x_rsf, x_rs1;
    logic [31:0] m_ir, m_pc, m_rw, m_frw, m_mw, m_fs, m_st, m_rsf, m_rs1, m_ill;
    logic [1:0]  obs_imm;
    int tf, w, e, d, endt;
    x_ir = '0; x_pc = '0; x_rw = '0; x_frw = '0; x_mw = '0;
    x_fs = '0; x_st = '0; x_rsf = '0; x_rs1 = '0;
    m_ir = '0; m_pc = '0; m_rw = '0; m_frw = '0; m_mw = '0;
    m_fs = '0; m_st = '0; m_rsf = '0; m_rs1 = '0; m_ill = '0;
    obs_imm = '0;
    for (int t = 0; t < 32; t++) begin
      rdy[t]  = ($urandom_range(0, 2) != 0) || (t % 4 == 3);
      dn[t]   = ($urandom_range(0, 3) == 0) || (t % 6 == 5);
      zr[t]   = 1'($urandom_range(0, 1));
      idst[t] = 1'($urandom_range(0, 1));
    end

    // Fetch completes on the first ready cycle, decode follows
    tf = first_rdy(0);
    x_ir[tf] = 1'b1;
    x_pc[tf] = 1'b1;
    if (opc == OP_LW || opc == OP_FLW) begin
      w = first_rdy(tf + 3);
      if (opc == OP_LW) x_rw[w+1] = 1'b1;
      else begin
        x_frw[w+1] = 1'b1;
        x_rsf[w+1] = 1'b1;
      end
      x_rs1[w+1] = 1'b1;
      endt = w + 2;
    end else if (opc == OP_SW || opc == OP_FSW) begin
      w = first_rdy(tf + 3);
      for (int k = tf + 3; k <= w; k++) begin
        x_mw[k] = 1'b1;
        if (opc == OP_FSW) x_fs[k] = 1'b1;
      end
      endt = w + 1;
    end else if (opc == OP_R || opc == OP_I) begin
      x_rw[tf+3] = 1'b1;
      endt = tf + 4;
    end else if (opc == OP_BEQ) begin
      x_pc[tf+2] = zr[tf+2];
      endt = tf + 3;
    end else if (opc == OP_JAL) begin
      x_pc[tf+2] = 1'b1;
      x_rw[tf+3] = 1'b1;
      endt = tf + 4;
    end else begin
      e = tf + 2;
      d = e;
      while (d < 31 && !dn[d]) d++;
      x_st[e] = 1'b1;
      if (idst[d]) x_rw[d+1] = 1'b1;
      else x_frw[d+1] = 1'b1;
      endt = d + 2;
    end

    for (int t = 0; t < endt; t++) begin
      bus.op = opc;
      bus.mem_ready = rdy[t];
      bus.zero = zr[t];
      bus.fpu_done = dn[t];
      bus.fpu_int_dest = idst[t];
      @(negedge clk);
      m_ir[t]  = bus.IRWrite;
      m_pc[t]  = bus.PCWrite;
      m_rw[t]  = bus.RegWrite;
      m_frw[t] = bus.float_RegWrite;
      m_mw[t]  = bus.MemWrite;
      m_fs[t]  = bus.float_store;
      m_st[t]  = bus.fpu_start;
      m_rsf[t] = bus.ResultSrc_float;
      m_rs1[t] = (bus.ResultSrc == 2'b01);
      m_ill[t] = bus.illegal_op;
      if (t == tf + 1) obs_imm = bus.ImmSrc;
      @(posedge clk);
      #1;
    end
    check_val($sformatf("IRWrite op=%b", opc), m_ir, x_ir);
    check_val($sformatf("PCWrite op=%b", opc), m_pc, x_pc);
    check_val($sformatf("RegWrite op=%b", opc), m_rw, x_rw);
    check_val($sformatf("float_RegWrite op=%b", opc), m_frw, x_frw);
    check_val($sformatf("MemWrite op=%b", opc), m_mw, x_mw);
    check_val($sformatf("float_store op=%b", opc), m_fs, x_fs);
    check_val($sformatf("fpu_start op=%b", opc), m_st, x_st);
    check_val($sformatf("ResultSrc_float op=%b", opc), m_rsf, x_rsf);
    check_val($sformatf("ResultSrc01 op=%b", opc), m_rs1, x_rs1);
    check_val($sformatf("illegal_op op=%b", opc), m_ill, 32'd0);
    check_val($sformatf("ImmSrc op=%b", opc), 32'(obs_imm), 32'(exp_imm(opc)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op = OP_JAL; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    bus.fpu_done = 1'b0; bus.fpu_int_dest = 1'b0;
    bus2.op = 7'd0; bus2.zero = 1'b0; bus2.mem_ready = 1'b0;
    bus2.fpu_done = 1'b0; bus2.fpu_int_dest = 1'b0;
    do_reset();

    // Every opcode once, then a random stream
    for (int k = 0; k < 9; k++) run_instr(pick_op(k));
    for (int n = 0; n < 40; n++) run_instr(pick_op($urandom_range(0, 8)));

    // Illegal opcode on the main DUT, flw on the F-disabled DUT
    do_reset();
    bus.op = 7'b1111111; bus.mem_ready = 1'b1; bus.zero = 1'b1;
    bus2.op = OP_FLW;    bus2.mem_ready = 1'b1; bus2.zero = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t == 2 || t == 5) begin
        check_val($sformatf("illegal_trap t=%0d", t),
                  32'({bus.illegal_op, bus.trap_cause, w_en}), 32'({1'b1, 2'b01, 6'd0}));
        check_val($sformatf("nof_trap t=%0d", t),
                  32'({bus2.illegal_op, bus2.trap_cause, w_en2}), 32'({1'b1, 2'b01, 6'd0}));
      end
      @(posedge clk);
      #1;
    end
    bus2.mem_ready = 1'b0;

    // FPU timeout: 8 cycles in FPU_EXEC (cycles 2..9), trap visible at 10
    do_reset();
    begin
      logic [31:0] m_st;
      m_st = '0;
      bus.op = OP_FP; bus.mem_ready = 1'b1; bus.fpu_done = 1'b0;
      for (int t = 0; t < 15; t++) begin
        @(negedge clk);
        m_st[t] = bus.fpu_start;
        if (t == 9) check_val("fpu_to_before", 32'(bus.illegal_op), 32'd0);
        if (t == 10 || t == 14)
          check_val($sformatf("fpu_to_trap t=%0d", t),
                    32'({bus.illegal_op, bus.trap_cause, w_en}), 32'({1'b1, 2'b10, 6'd0}));
        @(posedge clk);
        #1;
      end
      check_val("fpu_to_start_pulse", m_st, 32'h4);
    end

    // Reset while waiting in MEMREAD
    do_reset();
    bus.op = OP_LW;
    for (int t = 0; t < 6; t++) begin
      bus.mem_ready = (t == 0) || (t >= 4);
      rst = (t == 4);
      @(negedge clk);
      if (t == 4) check_val("midrst_enables", 32'(w_en), 32'd0);
      if (t == 5)
        check_val("midrst_fetch", 32'({bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite}),
                  32'(4'b0110));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_fp_controller.md
Name: multicycle_fp_controller

Overview:
Multi-cycle control unit for the RV32IF datapath. It replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It stalls on a memory-ready handshake, launches and waits on a variable-latency FPU, and traps on illegal opcodes or an FPU timeout. It sits between the instruction register (op, ALU zero flag) and the shared-memory multi-cycle datapath.

Parameters:
FPU_TIMEOUT, 64, max cycles spent in FPU_EXEC waiting for fpu_done before trapping; 0 disables the timeout.
ENABLE_F, 1, 1 = F-extension opcodes (0000111, 0100111, 1010011) decoded; 0 = those opcodes trap as illegal.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
op  in  7  opcode from the instruction register; held stable after FETCH.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
fpu_done  in  1  FPU result valid this cycle.
fpu_int_dest  in  1  FPU op writes the integer register file (compare or fcvt.w); sampled with fpu_done.
PCWrite  out  1  PC register enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
IRWrite  out  1  instruction register enable.
MemWrite  out  1  memory write strobe.
ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult.
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
RegWrite  out  1  integer register file write.
float_RegWrite  out  1  float register file write.
float_store  out  1  store data taken from the float register file.
ResultSrc_float  out  1  float writeback takes ReadData (flw).
fpu_start  out  1  single-cycle FPU launch pulse.
illegal_op  out  1  sticky trap flag.
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = FPU timeout.

Behaviour:
- Reset: while rst is high, PCWrite, IRWrite, MemWrite, RegWrite, float_RegWrite and fpu_start are forced to 0. At the next edge, state = FETCH, timeout counter = 0, illegal_op = 0, trap_cause = 00.
- Outputs are decoded from the state (Moore). The exceptions are PCWrite and IRWrite, which also depend on mem_ready and zero. Any output not listed for a state is 0.
- ImmSrc is decoded from op in every state: lw/flw/addi-type = 00, sw/fsw = 01, beq = 10, jal = 11, otherwise 00.
- FETCH: AdrSrc = 0; ALUSrcA = 00; ALUSrcB = 10; ALUOp = 00; ResultSrc = 10; IRWrite = PCWrite = mem_ready. Holds until mem_ready = 1, then goes to DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch-target precompute). Next state by op:
  - 0000011 / 0000111 / 0100011 / 0100111 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 1010011 -> FPU_EXEC
  - anything else, or any F opcode with ENABLE_F = 0 -> TRAP with cause 01
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc = 01. For lw: RegWrite = 1. For flw: float_RegWrite = 1 and ResultSrc_float = 1. Then FETCH.
- MEMWRITE: AdrSrc = 1; MemWrite = 1 every cycle in the state; float_store = 1 for fsw. The write commits on the mem_ready cycle, then FETCH.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10, then ALUWB.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10, then ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, PCWrite = zero, then FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1, then ALUWB (writes rd = PC+4).
- FPU_EXEC:
  - fpu_start = 1 only on the first cycle in the state.
  - The counter clears on entry and increments each cycle without fpu_done.
  - fpu_done (including on the entry cycle) -> FPU_WB; the registered copy of fpu_int_dest is captured.
  - If FPU_TIMEOUT != 0 and the counter reaches FPU_TIMEOUT - 1 without fpu_done -> TRAP with cause 10.
  - fpu_done wins over timeout in the same cycle.
- FPU_WB: if the captured fpu_int_dest = 1, RegWrite = 1; otherwise float_RegWrite = 1. Then FETCH.
- TRAP: illegal_op = 1, trap_cause holds its value, all enables are 0. The state persists until rst.
- Reset mid-operation (including during a pending memory or FPU wait): abandons immediately, with no write strobes while rst is high.
- Latency without stalls: lw/flw = 5, sw/fsw = 4, R/I = 4, beq = 3, jal = 4, FPU = 3 + FPU wait cycles.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_FLW, OP_FSW, OP_FP
  - the state enumeration
  - encodings for ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc and trap_cause
- One sub-module, imm_src_decoder: combinational op -> ImmSrc, instantiated once.

Test Plan:
- lw, mem_ready = 1 throughout -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 and ResultSrc = 01 in cycle 5 only.
- fsw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite and float_store held for 4 cycles; FETCH re-entered the cycle after mem_ready.
- beq with zero = 1, then with zero = 0 -> PCWrite = 1 and 0 respectively in the BEQ cycle; 3 cycles total in both cases.
- OP-FP: fpu_done after 5 cycles with fpu_int_dest = 1 -> fpu_start is a single pulse; RegWrite = 1 and float_RegWrite = 0 in FPU_WB. Repeat with fpu_int_dest = 0 -> float_RegWrite = 1.
- OP-FP with FPU_TIMEOUT = 8 and no fpu_done -> TRAP after 8 cycles in FPU_EXEC; illegal_op = 1, trap_cause = 10, sticky until rst.
- op = 1111111, then op = 0000111 with ENABLE_F = 0 -> TRAP with cause 01. Asserting rst mid-MEMREAD returns to FETCH with all enables 0.
